// File: rtl/qtable_update_engine.sv
// Neighbour-table / known-cluster-head update engine: one decoded routing packet per
// transaction, sequential table scan, then a single registered write and a done pulse.
module qtable_update_engine #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 16,
    parameter int MAX_CH        = 8,
    parameter int IDX_WIDTH     = 5,
    parameter bit REPLACE_MODE  = 1'b1,
    parameter bit EVICT_DEAD    = 1'b1
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  pkt_valid_i,
    output logic                  pkt_ready_o,
    input  logic [WORD_WIDTH-1:0] f_source_id_i,
    input  logic [WORD_WIDTH-1:0] f_cluster_id_i,
    input  logic [WORD_WIDTH-1:0] f_energy_i,
    input  logic [WORD_WIDTH-1:0] f_qvalue_i,
    input  logic                  tbl_clear_i,
    input  logic [IDX_WIDTH-1:0]  rd_idx_i,
    output logic [WORD_WIDTH-1:0] rd_nbr_id_o,
    output logic [WORD_WIDTH-1:0] rd_nbr_cid_o,
    output logic [WORD_WIDTH-1:0] rd_nbr_energy_o,
    output logic [WORD_WIDTH-1:0] rd_nbr_q_o,
    output logic [WORD_WIDTH-1:0] rd_ch_id_o,
    output logic [IDX_WIDTH-1:0]  nbr_count_o,
    output logic [IDX_WIDTH-1:0]  ch_count_o,
    output logic                  done_o,
    output logic                  nbr_drop_o,
    output logic                  ch_overflow_o
);
    localparam int NA = (MAX_NEIGHBORS > 1) ? $clog2(MAX_NEIGHBORS) : 1;
    localparam int CA = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam logic [IDX_WIDTH-1:0] NMAX = IDX_WIDTH'(MAX_NEIGHBORS);
    localparam logic [IDX_WIDTH-1:0] CMAX = IDX_WIDTH'(MAX_CH);

    typedef enum logic [2:0] {S_IDLE, S_NSRCH, S_NWR, S_CSRCH, S_CWR, S_DONE} state_t;

    // Storage padded to a power of two so every index slice stays in range.
    logic [WORD_WIDTH-1:0] nbr_id_q  [1<<NA];
    logic [WORD_WIDTH-1:0] nbr_cid_q [1<<NA];
    logic [WORD_WIDTH-1:0] nbr_en_q  [1<<NA];
    logic [WORD_WIDTH-1:0] nbr_qv_q  [1<<NA];
    logic [WORD_WIDTH-1:0] ch_id_q   [1<<CA];

    state_t                state_q;
    logic [IDX_WIDTH-1:0]  nbr_count_q, ch_count_q, scan_q;
    logic [NA-1:0]         hit_idx_q, min_idx_q;
    logic                  hit_q, ready_q, done_q, drop_q, ovf_q;
    logic [WORD_WIDTH-1:0] min_q_q, src_q, cid_q, en_q, qv_q;

    logic [NA-1:0]         nscan, nlast, nappend;
    logic [CA-1:0]         cscan;
    logic                  n_end, n_hit, c_end, c_hit, dead, n_room, c_room;
    logic                  nwe_d;
    logic [NA-1:0]         nwidx_d;
    logic [WORD_WIDTH-1:0] nw_id_d, nw_cid_d, nw_en_d, nw_qv_d;

    assign nscan   = scan_q[NA-1:0];
    assign cscan   = scan_q[CA-1:0];
    assign nlast   = NA'(nbr_count_q - IDX_WIDTH'(1));
    assign nappend = nbr_count_q[NA-1:0];
    assign n_end   = (scan_q == nbr_count_q);
    assign n_hit   = (nbr_id_q[nscan] == src_q);
    assign c_end   = (scan_q == ch_count_q);
    assign c_hit   = (ch_id_q[cscan] == src_q);
    assign dead    = (en_q == '0);
    assign n_room  = (nbr_count_q < NMAX);
    assign c_room  = (ch_count_q < CMAX);

    // Neighbour write port: a hit rewrites in place, a dead hit pulls the last entry
    // down into the hole, a live miss appends or overwrites the min-Q victim.
    always_comb begin
        nwe_d    = 1'b0;
        nwidx_d  = hit_idx_q;
        nw_id_d  = src_q;
        nw_cid_d = cid_q;
        nw_en_d  = en_q;
        nw_qv_d  = qv_q;
        if (state_q == S_NWR) begin
            if (hit_q) begin
                nwe_d = 1'b1;
                if (EVICT_DEAD && dead) begin
                    nw_id_d  = nbr_id_q[nlast];
                    nw_cid_d = nbr_cid_q[nlast];
                    nw_en_d  = nbr_en_q[nlast];
                    nw_qv_d  = nbr_qv_q[nlast];
                end
            end else if (!dead && (n_room || REPLACE_MODE)) begin
                nwe_d   = 1'b1;
                nwidx_d = n_room ? nappend : min_idx_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (nrst && nwe_d) begin
            nbr_id_q[nwidx_d]  <= nw_id_d;
            nbr_cid_q[nwidx_d] <= nw_cid_d;
            nbr_en_q[nwidx_d]  <= nw_en_d;
            nbr_qv_q[nwidx_d]  <= nw_qv_d;
        end
        if (nrst && state_q == S_CWR && c_room)
            ch_id_q[ch_count_q[CA-1:0]] <= src_q;
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            nbr_count_q <= '0;
            ch_count_q  <= '0;
            scan_q      <= '0;
            hit_idx_q   <= '0;
            min_idx_q   <= '0;
            min_q_q     <= '0;
            hit_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            src_q       <= '0;
            cid_q       <= '0;
            en_q        <= '0;
            qv_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tbl_clear_i) begin
                        nbr_count_q <= '0;
                        ch_count_q  <= '0;
                        drop_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                    end else if (pkt_valid_i) begin
                        src_q   <= f_source_id_i;
                        cid_q   <= f_cluster_id_i;
                        en_q    <= f_energy_i;
                        qv_q    <= f_qvalue_i;
                        scan_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_NSRCH;
                    end
                end
                S_NSRCH: begin
                    if (n_end) begin
                        hit_q   <= 1'b0;
                        state_q <= S_NWR;
                    end else if (n_hit) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= nscan;
                        state_q   <= S_NWR;
                    end else begin
                        // strict less-than keeps the lower index on Q ties
                        if (scan_q == '0 || nbr_qv_q[nscan] < min_q_q) begin
                            min_q_q   <= nbr_qv_q[nscan];
                            min_idx_q <= nscan;
                        end
                        scan_q <= scan_q + IDX_WIDTH'(1);
                    end
                end
                S_NWR: begin
                    if (hit_q) begin
                        if (EVICT_DEAD && dead)
                            nbr_count_q <= nbr_count_q - IDX_WIDTH'(1);
                    end else if (!dead) begin
                        if (n_room)
                            nbr_count_q <= nbr_count_q + IDX_WIDTH'(1);
                        else if (!REPLACE_MODE)
                            drop_q <= 1'b1;
                    end
                    scan_q <= '0;
                    if (cid_q == src_q) begin
                        state_q <= S_CSRCH;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_CSRCH: begin
                    if (c_end) begin
                        state_q <= S_CWR;
                    end else if (c_hit) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        scan_q <= scan_q + IDX_WIDTH'(1);
                    end
                end
                S_CWR: begin
                    if (c_room) ch_count_q <= ch_count_q + IDX_WIDTH'(1);
                    else        ovf_q      <= 1'b1;
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Out-of-range read indices return zero rather than aliasing.
    assign rd_nbr_id_o     = (rd_idx_i < NMAX) ? nbr_id_q[rd_idx_i[NA-1:0]]  : '0;
    assign rd_nbr_cid_o    = (rd_idx_i < NMAX) ? nbr_cid_q[rd_idx_i[NA-1:0]] : '0;
    assign rd_nbr_energy_o = (rd_idx_i < NMAX) ? nbr_en_q[rd_idx_i[NA-1:0]]  : '0;
    assign rd_nbr_q_o      = (rd_idx_i < NMAX) ? nbr_qv_q[rd_idx_i[NA-1:0]]  : '0;
    assign rd_ch_id_o      = (rd_idx_i < CMAX) ? ch_id_q[rd_idx_i[CA-1:0]]   : '0;
    assign nbr_count_o     = nbr_count_q;
    assign ch_count_o      = ch_count_q;
    assign pkt_ready_o     = ready_q;
    assign done_o          = done_q;
    assign nbr_drop_o      = drop_q;
    assign ch_overflow_o   = ovf_q;
endmodule

// File: tb/tb_qtable_update_engine.sv
// Scoreboard bench: two engines (replace / drop on full) share stimulus; done events
// pop expected completion cycle and counts.
module tb_qtable_update_engine;
    localparam int WW = 16, NM = 4, NC = 2, IW = 5;

    logic clock = 1'b0;
    logic nrst = 1'b0;
    logic pkt_valid = 1'b0, tbl_clear = 1'b0;
    logic [WW-1:0] f_src = '0, f_cid = '0, f_en = '0, f_q = '0;
    logic [IW-1:0] rd_idx = '0;

    logic a_ready, a_done, a_drop, a_ovf, b_ready, b_done, b_drop, b_ovf;
    logic [WW-1:0] a_rid, a_rcid, a_ren, a_rq, a_rch, b_rid, b_rcid, b_ren, b_rq, b_rch;
    logic [IW-1:0] a_ncnt, a_ccnt, b_ncnt, b_ccnt;

    always #5 clock = ~clock;

    qtable_update_engine #(.WORD_WIDTH(WW), .MAX_NEIGHBORS(NM), .MAX_CH(NC), .IDX_WIDTH(IW),
                           .REPLACE_MODE(1'b1), .EVICT_DEAD(1'b1)) u_rep (
        .clock(clock), .nrst(nrst), .pkt_valid_i(pkt_valid), .pkt_ready_o(a_ready),
        .f_source_id_i(f_src), .f_cluster_id_i(f_cid), .f_energy_i(f_en), .f_qvalue_i(f_q),
        .tbl_clear_i(tbl_clear), .rd_idx_i(rd_idx),
        .rd_nbr_id_o(a_rid), .rd_nbr_cid_o(a_rcid), .rd_nbr_energy_o(a_ren), .rd_nbr_q_o(a_rq),
        .rd_ch_id_o(a_rch), .nbr_count_o(a_ncnt), .ch_count_o(a_ccnt), .done_o(a_done),
        .nbr_drop_o(a_drop), .ch_overflow_o(a_ovf));

    qtable_update_engine #(.WORD_WIDTH(WW), .MAX_NEIGHBORS(NM), .MAX_CH(NC), .IDX_WIDTH(IW),
                           .REPLACE_MODE(1'b0), .EVICT_DEAD(1'b1)) u_drp (
        .clock(clock), .nrst(nrst), .pkt_valid_i(pkt_valid), .pkt_ready_o(b_ready),
        .f_source_id_i(f_src), .f_cluster_id_i(f_cid), .f_energy_i(f_en), .f_qvalue_i(f_q),
        .tbl_clear_i(tbl_clear), .rd_idx_i(rd_idx),
        .rd_nbr_id_o(b_rid), .rd_nbr_cid_o(b_rcid), .rd_nbr_energy_o(b_ren), .rd_nbr_q_o(b_rq),
        .rd_ch_id_o(b_rch), .nbr_count_o(b_ncnt), .ch_count_o(b_ccnt), .done_o(b_done),
        .nbr_drop_o(b_drop), .ch_overflow_o(b_ovf));

    typedef struct { int cyc; int nbr; int ch; } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int n_chk = 0, n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (a_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("nbr_count", a_ncnt, e.nbr);
                chk("ch_count", a_ccnt, e.ch);
                chk("drp_done", b_done, 1);
            end
        end
    end

    task automatic send(input int src, input int cid, input int en, input int q,
                        input int lat, input int nbr, input int ch);
        @(negedge clock);
        pkt_valid = 1'b1;
        f_src = WW'(src); f_cid = WW'(cid); f_en = WW'(en); f_q = WW'(q);
        sb.push_back('{cyc: cyc + lat, nbr: nbr, ch: ch});
        @(negedge clock);
        pkt_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic clear();
        @(negedge clock); tbl_clear = 1'b1;
        @(negedge clock); tbl_clear = 1'b0;
    endtask

    task automatic rd(input int idx);
        rd_idx = IW'(idx);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_nbr_count", a_ncnt, 0);
        chk("rst_ch_count", a_ccnt, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_done", a_done, 0);
        chk("rst_drop", b_drop, 0);
        chk("rst_ovf", a_ovf, 0);
        nrst = 1'b1;

        send(5, 9, 100, 20, 3, 1, 0);
        rd(0);
        chk("e0_id", a_rid, 5); chk("e0_cid", a_rcid, 9);
        chk("e0_en", a_ren, 100); chk("e0_q", a_rq, 20);

        send(9, 9, 80, 30, 6, 2, 1);
        rd(0); chk("ch0_id", a_rch, 9);
        send(9, 9, 81, 31, 5, 2, 1);
        rd(1);
        chk("e1_id", a_rid, 9); chk("e1_en_upd", a_ren, 81); chk("e1_q_upd", a_rq, 31);

        // full table, min-Q tie between slots 1 and 3
        clear();
        send(10, 99, 50, 10, 3, 1, 0);
        send(11, 99, 50, 3, 4, 2, 0);
        send(12, 99, 50, 7, 5, 3, 0);
        send(13, 99, 50, 3, 6, 4, 0);
        send(40, 99, 50, 50, 7, 4, 0);
        rd(1);
        chk("rep_e1_id", a_rid, 40); chk("rep_e1_q", a_rq, 50); chk("drp_e1_id", b_rid, 11);
        rd(3);
        chk("rep_e3_id", a_rid, 13);
        chk("rep_drop", a_drop, 0);
        chk("drp_drop", b_drop, 1);
        chk("drp_count", b_ncnt, 4);

        // dead-node eviction
        clear();
        chk("clr_drop", b_drop, 0);
        send(5, 99, 50, 1, 3, 1, 0);
        send(6, 99, 50, 1, 4, 2, 0);
        send(7, 99, 50, 1, 5, 3, 0);
        send(5, 99, 0, 1, 3, 2, 0);
        rd(0); chk("evict_e0_id", a_rid, 7);
        rd(1); chk("evict_e1_id", a_rid, 6);
        send(8, 99, 0, 1, 5, 2, 0);

        // known-CH list fill and overflow
        send(20, 20, 50, 9, 7, 3, 1);
        send(21, 21, 50, 9, 9, 4, 2);
        chk("ovf_before", a_ovf, 0);
        send(22, 22, 50, 9, 11, 4, 2);
        chk("ovf_after", a_ovf, 1);
        rd(1); chk("ch1_id", a_rch, 21);

        // reset while scanning
        @(negedge clock);
        pkt_valid = 1'b1; f_src = 16'd30; f_cid = 16'd99; f_en = 16'd50;
        @(negedge clock);
        pkt_valid = 1'b0; nrst = 1'b0;
        @(negedge clock);
        nrst = 1'b1;
        chk("rstmid_nbr", a_ncnt, 0);
        chk("rstmid_ch", a_ccnt, 0);
        chk("rstmid_ready", a_ready, 1);
        chk("rstmid_ovf", a_ovf, 0);
        repeat (10) @(negedge clock);
        chk("rstmid_idle", a_ready, 1);

        // clear beats a simultaneous packet
        send(50, 99, 50, 5, 3, 1, 0);
        @(negedge clock);
        tbl_clear = 1'b1; pkt_valid = 1'b1; f_src = 16'd60;
        @(negedge clock);
        tbl_clear = 1'b0; pkt_valid = 1'b0;
        chk("clrv_ready", a_ready, 1);
        chk("clrv_nbr", a_ncnt, 0);
        repeat (8) @(negedge clock);
        chk("clrv_nbr_late", a_ncnt, 0);
        chk("clrv_ready_late", a_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
